// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared constants for the serial-to-parallel receiver: byte width, default comma byte, FSM encoding.
package serial_to_parallel_rx_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] COM_BYTE_DEF = 8'hBC;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_LOCKING = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

endpackage

// File: rtl/com_detector.sv
// Combinational comma detector: flags when the candidate byte equals the comma byte.
module com_detector
  import serial_to_parallel_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM_BYTE = COM_BYTE_DEF
) (
  input  logic [BYTE_W-1:0] candidate,
  output logic              is_com_c
);

  assign is_com_c = (candidate == COM_BYTE);

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: aligns on comma bytes, locks after LOCK_COUNT aligned commas,
// then presents each completed non-comma byte on data_out.
module serial_to_parallel_rx
  import serial_to_parallel_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM_BYTE   = COM_BYTE_DEF,
  parameter int unsigned       LOCK_COUNT = 4
) (
  input  logic              clk16f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              byte_strobe
);

  localparam int unsigned CNT_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  logic [1:0]        state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  com_cnt_q, com_cnt_d;
  logic [BYTE_W-1:0] data_d;
  logic              valid_d;
  logic              active_d;
  logic              strobe_d;

  logic [BYTE_W-1:0] candidate_c;
  logic              is_com_c;
  logic              boundary_c;
  logic [CNT_W-1:0]  com_cnt_inc_c;

  assign candidate_c   = {shift_q[BYTE_W-2:0], data_in};
  assign boundary_c    = (bit_cnt_q == 3'd7);
  assign com_cnt_inc_c = com_cnt_q + CNT_W'(1);

  com_detector #(
    .COM_BYTE (COM_BYTE)
  ) u_com_detector (
    .candidate (candidate_c),
    .is_com_c  (is_com_c)
  );

  // State register and registered datapath/outputs
  always_ff @(posedge clk16f) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      com_cnt_q   <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      active      <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      com_cnt_q   <= com_cnt_d;
      data_out    <= data_d;
      valid_out   <= valid_d;
      active      <= active_d;
      byte_strobe <= strobe_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    shift_d   = candidate_c;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_out;
    valid_d   = valid_out;
    strobe_d  = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        bit_cnt_d = '0;
        if (is_com_c) begin
          // The match cycle itself is the first byte boundary
          strobe_d  = 1'b1;
          com_cnt_d = CNT_W'(1);
          state_d   = (LOCK_COUNT <= 1) ? ST_ACTIVE : ST_LOCKING;
        end
      end

      ST_LOCKING: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary_c) begin
          strobe_d = 1'b1;
          if (is_com_c) begin
            com_cnt_d = com_cnt_inc_c;
            if (com_cnt_inc_c == CNT_W'(LOCK_COUNT)) begin
              state_d = ST_ACTIVE;
            end
          end else begin
            com_cnt_d = '0;
            state_d   = ST_SEARCH;
          end
        end
      end

      ST_ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary_c) begin
          strobe_d = 1'b1;
          if (is_com_c) begin
            valid_d = 1'b0;
          end else begin
            data_d  = candidate_c;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_SEARCH;
        bit_cnt_d = '0;
        com_cnt_d = '0;
      end
    endcase

    active_d = (state_d == ST_ACTIVE);
  end

endmodule
